truth_table_sweeper: RTL

Sequencer that exercises a combinational circuit bank over every input combination. It drives the bank's input vector (A..D, one row per step) and waits a programmable settle time. It then samples the bank's outputs, packs them into a truth-table register, and checks them against an expected table. It sits between the bench/host and the Out_1/Out_2/Out_3 circuit bank and replaces the hand-written `#1` stimulus sweep with a clocked, restartable controller.

---
 rtl/truth_table_sweeper.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: clocked, restartable sweep of a combinational bank.
// Walks every input row. For each row it waits a settle time, then samples
// the bank outputs, packs them into a truth table and scores each row
// against an expected table.
module truth_table_sweeper #(
  parameter int NUM_INPUTS    = 4,
  parameter int NUM_OUTPUTS   = 3,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic                                       start,
  input  logic                                       abort,
  output logic [NUM_INPUTS-1:0]                      vec_out,
  input  logic [NUM_OUTPUTS-1:0]                     circ_in,
  input  logic [NUM_OUTPUTS*(2**NUM_INPUTS)-1:0]     exp_table,
  output logic                                       busy,
  output logic                                       row_valid,
  output logic [NUM_INPUTS-1:0]                      row_index,
  output logic [NUM_OUTPUTS-1:0]                     row_data,
  output logic [NUM_OUTPUTS*(2**NUM_INPUTS)-1:0]     table_out,
  output logic [NUM_INPUTS:0]                        mismatch_count,
  output logic                                       done,
  output logic                                       pass
);

  localparam int ROWS = 2**NUM_INPUTS;
  localparam int TW   = NUM_OUTPUTS*ROWS;
  // Counter only ever holds 0..SETTLE_CYCLES-1
  localparam int CW   = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0]         CNT_RELOAD = CW'(SETTLE_CYCLES-1);
  localparam logic [NUM_INPUTS:0]   MISM_MAX   = (NUM_INPUTS+1)'(ROWS);
  localparam logic [NUM_INPUTS-1:0] LAST_ROW   = NUM_INPUTS'(ROWS-1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETTLE = 2'd1;
  localparam logic [1:0] S_SAMPLE = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]             r_state;
  logic [NUM_INPUTS-1:0]  r_row;
  logic [CW-1:0]          r_cnt;
  logic [NUM_INPUTS-1:0]  r_vec;
  logic                   r_row_valid;
  logic [NUM_INPUTS-1:0]  r_row_index;
  logic [NUM_OUTPUTS-1:0] r_row_data;
  logic [TW-1:0]          r_table;
  logic [NUM_INPUTS:0]    r_mism;
  logic                   r_pass;

  logic [NUM_OUTPUTS-1:0] w_exp_slice;
  logic                   w_miss;
  logic [NUM_INPUTS:0]    w_mism_nxt;

  // Expected slice for the current row and the score after this sample
  always_comb begin
    w_exp_slice = exp_table[r_row*NUM_OUTPUTS +: NUM_OUTPUTS];
    w_miss      = (circ_in != w_exp_slice);
    w_mism_nxt  = (w_miss && (r_mism != MISM_MAX)) ? r_mism + 1'b1 : r_mism;
  end

  // Sweep FSM with row, settle counter, capture and scoring state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_row       <= '0;
      r_cnt       <= '0;
      r_vec       <= '0;
      r_row_valid <= 1'b0;
      r_row_index <= '0;
      r_row_data  <= '0;
      r_table     <= '0;
      r_mism      <= '0;
      r_pass      <= 1'b0;
    end else begin
      r_row_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // abort wins over a simultaneous start
          if (start && !abort) begin
            r_state <= S_SETTLE;
            r_row   <= '0;
            r_vec   <= '0;
            r_cnt   <= CNT_RELOAD;
            r_table <= '0;
            r_mism  <= '0;
            r_pass  <= 1'b0;
          end
        end
        S_SETTLE: begin
          if (abort) begin
            r_state <= S_IDLE;
            r_vec   <= '0;
          end else if (r_cnt == '0) begin
            r_state <= S_SAMPLE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_SAMPLE: begin
          // An abort here drops the row entirely, even the final one
          if (abort) begin
            r_state <= S_IDLE;
            r_vec   <= '0;
          end else begin
            r_table[r_row*NUM_OUTPUTS +: NUM_OUTPUTS] <= circ_in;
            r_row_data  <= circ_in;
            r_row_index <= r_row;
            r_row_valid <= 1'b1;
            r_mism      <= w_mism_nxt;
            if (r_row == LAST_ROW) begin
              r_state <= S_DONE;
              r_pass  <= (w_mism_nxt == '0);
            end else begin
              r_state <= S_SETTLE;
              r_row   <= r_row + 1'b1;
              r_vec   <= r_row + 1'b1;
              r_cnt   <= CNT_RELOAD;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_vec   <= '0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy           = (r_state == S_SETTLE) || (r_state == S_SAMPLE);
  assign done           = (r_state == S_DONE);
  assign vec_out        = r_vec;
  assign row_valid      = r_row_valid;
  assign row_index      = r_row_index;
  assign row_data       = r_row_data;
  assign table_out      = r_table;
  assign mismatch_count = r_mism;
  assign pass           = r_pass;

endmodule
